// File: rtl/hazard_scoreboard.sv
// Per-register busy/countdown scoreboard that stalls decode on RAW, WAW and in-flight overflow
// for variable- and fixed-latency producers. Define HAZARD_PERF_CNT_EN to add stall-cycle counters.
module hazard_scoreboard #(
  parameter int NREG         = 32,
  parameter int LAT_W        = 4,
  parameter int FWD_SLACK    = 1,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_d,
  input  logic [$clog2(NREG)-1:0] rs1_d,
  input  logic [$clog2(NREG)-1:0] rs2_d,
  input  logic                    rs_fpu_d,
  input  logic [$clog2(NREG)-1:0] rd_d,
  input  logic                    rd_fpu_d,
  input  logic                    reg_write_d,
  input  logic [LAT_W-1:0]        lat_d,
  input  logic                    flush_d,
  input  logic                    kill_e,
  input  logic                    global_stall,
  input  logic                    done_valid,
  input  logic [$clog2(NREG)-1:0] done_rd,
  input  logic                    done_fpu,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    bubble_e,
  output logic [NREG-1:0]         busy_int,
`ifdef HAZARD_PERF_CNT_EN
  output logic [NREG-1:0]         busy_fp,
  output logic [31:0]             raw_stall_cnt,
  output logic [31:0]             waw_stall_cnt,
  output logic [31:0]             full_stall_cnt
`else
  output logic [NREG-1:0]         busy_fp
`endif
);

  localparam int IW = $clog2(NREG);
  localparam int NE = 2 * NREG;
  localparam int EW = IW + 1;
  localparam int PW = $clog2(NE + 1);
  localparam logic [LAT_W-1:0] SLACK_C = LAT_W'(FWD_SLACK);
  localparam logic [LAT_W-1:0] ONE_C   = LAT_W'(1);
  localparam logic [PW-1:0]    MAXF_C  = PW'(MAX_INFLIGHT);

  // Entries 0..NREG-1 are the integer file, NREG..2*NREG-1 the FPU file.
  logic [NE-1:0]    busy_r;
  logic [NE-1:0]    var_r;
  logic [LAT_W-1:0] cnt_r [NE];
  logic             li_valid_r;
  logic [EW-1:0]    li_e_r;

  logic [NE-1:0] pend_s;
  logic [EW-1:0] rs1_e_s, rs2_e_s, rd_e_s, done_e_s;
  logic          raw_s, waw_s, full_s, hazard_s, trackable_s, issue_s;

  function automatic logic [EW-1:0] entry_idx(input logic fpu, input logic [IW-1:0] r);
    logic [EW-1:0] e;
    if (fpu) e = EW'(NREG) + {1'b0, r};
    else     e = {1'b0, r};
    return e;
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [NE-1:0] v);
    logic [PW-1:0] c;
    c = {PW{1'b0}};
    for (int i = 0; i < NE; i++) c = c + {{(PW-1){1'b0}}, v[i]};
    return c;
  endfunction

  assign rs1_e_s  = entry_idx(rs_fpu_d, rs1_d);
  assign rs2_e_s  = entry_idx(rs_fpu_d, rs2_d);
  assign rd_e_s   = entry_idx(rd_fpu_d, rd_d);
  assign done_e_s = entry_idx(done_fpu, done_rd);

  // Pending = result not yet reachable through the forwarding network.
  always_comb begin
    for (int e = 0; e < NE; e++) begin
      pend_s[e] = busy_r[e] & (var_r[e] | (cnt_r[e] > SLACK_C));
    end
  end

  assign raw_s       = valid_d & (pend_s[rs1_e_s] | pend_s[rs2_e_s]);
  assign waw_s       = valid_d & reg_write_d & busy_r[rd_e_s];
  assign full_s      = valid_d & reg_write_d & (popcount(busy_r) >= MAXF_C);
  assign hazard_s    = raw_s | waw_s | full_s;
  assign trackable_s = rd_fpu_d | (rd_d != {IW{1'b0}});
  assign issue_s     = ~rst & valid_d & reg_write_d & ~hazard_s & ~flush_d & ~global_stall & trackable_s;

  assign stall_f  = rst | hazard_s;
  assign stall_d  = rst | hazard_s;
  assign bubble_e = ~rst & hazard_s & ~global_stall & ~flush_d;
  assign busy_int = busy_r[NREG-1:0];
  assign busy_fp  = busy_r[NE-1:NREG];

  // Scoreboard entries: done/countdown first, then kill of the E-stage write, then new issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NE{1'b0}};
      var_r  <= {NE{1'b0}};
      for (int e = 0; e < NE; e++) cnt_r[e] <= {LAT_W{1'b0}};
    end else begin
      for (int e = 0; e < NE; e++) begin
        if (done_valid && (done_e_s == EW'(e)) && busy_r[e] && var_r[e]) begin
          busy_r[e] <= 1'b0;
          var_r[e]  <= 1'b0;
        end else if (!global_stall && busy_r[e] && !var_r[e]) begin
          if (cnt_r[e] == ONE_C) begin
            busy_r[e] <= 1'b0;
            cnt_r[e]  <= {LAT_W{1'b0}};
          end else begin
            cnt_r[e] <= cnt_r[e] - ONE_C;
          end
        end
        if (kill_e && li_valid_r && (li_e_r == EW'(e))) begin
          busy_r[e] <= 1'b0;
          var_r[e]  <= 1'b0;
          cnt_r[e]  <= {LAT_W{1'b0}};
        end
        if (issue_s && (rd_e_s == EW'(e))) begin
          busy_r[e] <= 1'b1;
          var_r[e]  <= (lat_d == {LAT_W{1'b0}});
          cnt_r[e]  <= lat_d;
        end
      end
    end
  end

  // Last-issue tracker: names the write now in E so kill_e can retract it.
  always_ff @(posedge clk) begin
    if (rst) begin
      li_valid_r <= 1'b0;
      li_e_r     <= {EW{1'b0}};
    end else if (issue_s) begin
      li_valid_r <= 1'b1;
      li_e_r     <= rd_e_s;
    end else if (kill_e || !global_stall) begin
      li_valid_r <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall-cause counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_stall_cnt  <= 32'd0;
      waw_stall_cnt  <= 32'd0;
      full_stall_cnt <= 32'd0;
    end else begin
      if (raw_s && (raw_stall_cnt != 32'hFFFF_FFFF))   raw_stall_cnt  <= raw_stall_cnt + 32'd1;
      if (waw_s && (waw_stall_cnt != 32'hFFFF_FFFF))   waw_stall_cnt  <= waw_stall_cnt + 32'd1;
      if (full_s && (full_stall_cnt != 32'hFFFF_FFFF)) full_stall_cnt <= full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic,
// all checked against a per-register "remaining cycles" reference model.
module tb_hazard_scoreboard;
  localparam int NREG = 8;
  localparam int LAT_W = 4;
  localparam int FWD_SLACK = 1;
  localparam int MAX_INFLIGHT = 2;

  logic clk = 1'b0;
  logic rst, valid_d, rs_fpu_d, rd_fpu_d, reg_write_d, flush_d, kill_e, global_stall, done_valid, done_fpu;
  logic [2:0] rs1_d, rs2_d, rd_d, done_rd;
  logic [LAT_W-1:0] lat_d;
  logic stall_f, stall_d, bubble_e;
  logic [NREG-1:0] busy_int, busy_fp;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] raw_stall_cnt, waw_stall_cnt, full_stall_cnt;
`endif

  hazard_scoreboard #(.NREG(NREG), .LAT_W(LAT_W), .FWD_SLACK(FWD_SLACK), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs_fpu_d(rs_fpu_d),
    .rd_d(rd_d), .rd_fpu_d(rd_fpu_d), .reg_write_d(reg_write_d), .lat_d(lat_d), .flush_d(flush_d),
    .kill_e(kill_e), .global_stall(global_stall), .done_valid(done_valid), .done_rd(done_rd),
    .done_fpu(done_fpu), .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
`ifdef HAZARD_PERF_CNT_EN
    .raw_stall_cnt(raw_stall_cnt), .waw_stall_cnt(waw_stall_cnt), .full_stall_cnt(full_stall_cnt),
`endif
    .busy_int(busy_int), .busy_fp(busy_fp));

  always #5 clk = ~clk;

  wire [2*NREG+2:0] obs = {stall_f, stall_d, bubble_e, busy_int, busy_fp};

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: file f (0=int,1=fpu), register r.
  bit m_busy [2][NREG];
  bit m_var  [2][NREG];
  int m_rem  [2][NREG];
  bit m_li_v;
  int m_li_f, m_li_r;
  bit e_haz, e_issue;
  logic [2*NREG+2:0] exp_v;

  function automatic bit pend(int f, int r);
    return m_busy[f][r] && (m_var[f][r] || m_rem[f][r] > FWD_SLACK);
  endfunction

  task automatic model_comb();
    int nbusy;
    bit stall, bubble;
    nbusy = 0;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < NREG; r++) nbusy += int'(m_busy[f][r]);
    e_haz = (valid_d && (pend(int'(rs_fpu_d), int'(rs1_d)) || pend(int'(rs_fpu_d), int'(rs2_d))))
         || (valid_d && reg_write_d && m_busy[rd_fpu_d][rd_d])
         || (valid_d && reg_write_d && nbusy >= MAX_INFLIGHT);
    e_issue = !rst && valid_d && reg_write_d && !e_haz && !flush_d && !global_stall
              && (rd_fpu_d || rd_d != 3'd0);
    stall  = rst || e_haz;
    bubble = !rst && e_haz && !global_stall && !flush_d;
    exp_v = '0;
    exp_v[2*NREG+2] = stall;
    exp_v[2*NREG+1] = stall;
    exp_v[2*NREG]   = bubble;
    for (int r = 0; r < NREG; r++) begin
      exp_v[NREG+r] = m_busy[0][r];
      exp_v[r]      = m_busy[1][r];
    end
  endtask

  task automatic model_clock();
    bit iss;
    if (rst) begin
      for (int f = 0; f < 2; f++)
        for (int r = 0; r < NREG; r++) begin m_busy[f][r] = 0; m_var[f][r] = 0; m_rem[f][r] = 0; end
      m_li_v = 0;
    end else begin
      model_comb();
      iss = e_issue;
      if (done_valid && m_busy[done_fpu][done_rd] && m_var[done_fpu][done_rd]) begin
        m_busy[done_fpu][done_rd] = 0;
        m_var[done_fpu][done_rd]  = 0;
      end
      if (!global_stall)
        for (int f = 0; f < 2; f++)
          for (int r = 0; r < NREG; r++)
            if (m_busy[f][r] && !m_var[f][r]) begin
              m_rem[f][r]--;
              if (m_rem[f][r] == 0) m_busy[f][r] = 0;
            end
      if (kill_e && m_li_v) begin
        m_busy[m_li_f][m_li_r] = 0; m_var[m_li_f][m_li_r] = 0; m_rem[m_li_f][m_li_r] = 0;
      end
      if (iss) begin
        m_busy[rd_fpu_d][rd_d] = 1;
        m_var[rd_fpu_d][rd_d]  = (lat_d == 0);
        m_rem[rd_fpu_d][rd_d]  = int'(lat_d);
        m_li_v = 1; m_li_f = int'(rd_fpu_d); m_li_r = int'(rd_d);
      end else if (kill_e || !global_stall) begin
        m_li_v = 0;
      end
    end
  endtask

  task automatic set_idle();
    valid_d = 0; rs1_d = 3'd0; rs2_d = 3'd0; rs_fpu_d = 0; rd_d = 3'd0; rd_fpu_d = 0;
    reg_write_d = 0; lat_d = 4'd0; flush_d = 0; kill_e = 0; global_stall = 0;
    done_valid = 0; done_rd = 3'd0; done_fpu = 0;
  endtask

  task automatic advance();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) advance();
  endtask

  task automatic do_issue(input bit f, input int r, input int lat);
    set_idle();
    valid_d = 1; reg_write_d = 1; rd_fpu_d = f; rd_d = 3'(r); lat_d = 4'(lat);
    advance();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle(); rst = 1; valid_d = 1; reg_write_d = 1; rd_d = 3'd2;
    advance();
    #1; model_comb(); n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, exp_v); end
    advance();
    set_idle(); rst = 0;
    #1; model_comb(); n_cmp++;
    if ({stall_f, stall_d, bubble_e, busy_int, busy_fp} !== {3'b000, 16'h0000}) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", obs, {3'b000, 16'h0000});
    end
    advance();
  endtask

  task automatic test_fixed_latency();
    int stalls = 0;
    bit go;
    do_issue(0, 5, 3);
    valid_d = 1; rs1_d = 3'd5;
    for (int i = 0; i < 8; i++) begin
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL fixed_lat c%0d: got %h expected %h", i, obs, exp_v); end
      if (stall_d) stalls++;
      go = !e_haz;
      advance();
      if (go) break;
    end
    set_idle();
    #1; n_cmp++;
    if (stalls !== 2) begin n_fail++; $display("FAIL fixed_lat_stalls: got %0d expected 2", stalls); end
    if (busy_int[5] !== 1'b0) begin n_fail++; $display("FAIL fixed_lat_busy: got %b expected 0", busy_int[5]); end
    n_cmp++;
    advance();
  endtask

  task automatic test_variable_latency();
    int stalls = 0;
    bit go;
    do_issue(1, 3, 0);
    valid_d = 1; rs_fpu_d = 1; rs2_d = 3'd3;
    for (int i = 0; i < 12; i++) begin
      done_valid = (i == 5); done_rd = 3'd3; done_fpu = 1;
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL var_lat c%0d: got %h expected %h", i, obs, exp_v); end
      if (stall_d) stalls++;
      go = !e_haz;
      advance();
      if (go) break;
    end
    set_idle();
    #1; n_cmp++;
    if (stalls !== 6 || busy_fp[3] !== 1'b0) begin
      n_fail++; $display("FAIL var_lat_stalls: got %0d/%b expected 6/0", stalls, busy_fp[3]);
    end
    advance();
  endtask

  task automatic test_kill();
    do_issue(0, 7, 0);
    kill_e = 1;
    #1; model_comb(); n_cmp++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL kill_cycle: got %h expected %h", obs, exp_v); end
    advance();
    set_idle(); valid_d = 1; rs1_d = 3'd7;
    #1; model_comb(); n_cmp++;
    if (stall_d !== 1'b0 || busy_int[7] !== 1'b0 || obs !== exp_v) begin
      n_fail++; $display("FAIL kill_reader: got %h expected %h", obs, exp_v);
    end
    advance();
    set_idle();
  endtask

  task automatic test_global_stall();
    int stalls = 0;
    bit go;
    do_issue(0, 4, 3);
    valid_d = 1; rs1_d = 3'd4; global_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v || stall_d !== 1'b1 || bubble_e !== 1'b0) begin
        n_fail++; $display("FAIL gstall_hold c%0d: got %h expected %h", i, obs, exp_v);
      end
      if (stall_d) stalls++;
      advance();
    end
    global_stall = 0;
    for (int i = 0; i < 8; i++) begin
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL gstall_run c%0d: got %h expected %h", i, obs, exp_v); end
      if (stall_d) stalls++;
      go = !e_haz;
      advance();
      if (go) break;
    end
    set_idle();
    n_cmp++;
    if (stalls !== 6) begin n_fail++; $display("FAIL gstall_stalls: got %0d expected 6", stalls); end
    idle_cycles(2);
  endtask

  task automatic test_full_waw();
    int stalls = 0;
    bit go;
    do_issue(0, 1, 0);
    do_issue(0, 2, 0);
    valid_d = 1; reg_write_d = 1; rd_d = 3'd3; lat_d = 4'd2;
    for (int i = 0; i < 3; i++) begin
      done_valid = (i == 1); done_rd = 3'd1; done_fpu = 0;
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v || stall_d !== (i < 2)) begin
        n_fail++; $display("FAIL full c%0d: got %h expected %h", i, obs, exp_v);
      end
      advance();
    end
    set_idle();
    for (int i = 0; i < 2; i++) begin
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL full_drain c%0d: got %h expected %h", i, obs, exp_v); end
      advance();
    end
    valid_d = 1; reg_write_d = 1; rd_d = 3'd2; lat_d = 4'd1;
    for (int i = 0; i < 10; i++) begin
      done_valid = (i == 2); done_rd = 3'd2; done_fpu = 0;
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL waw c%0d: got %h expected %h", i, obs, exp_v); end
      if (stall_d) stalls++;
      go = !e_haz;
      advance();
      if (go) break;
    end
    n_cmp++;
    if (stalls !== 3) begin n_fail++; $display("FAIL waw_stalls: got %0d expected 3", stalls); end
    set_idle(); valid_d = 1; reg_write_d = 1; rd_d = 3'd0; lat_d = 4'd0;
    #1; model_comb(); n_cmp++;
    if (obs !== exp_v || stall_d !== 1'b0) begin n_fail++; $display("FAIL x0_write: got %h expected %h", obs, exp_v); end
    advance();
    set_idle(); valid_d = 1;
    #1; model_comb(); n_cmp++;
    if (obs !== exp_v || stall_d !== 1'b0 || busy_int[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_reader: got %h expected %h", obs, exp_v);
    end
    advance();
    idle_cycles(2);
  endtask

  task automatic test_random();
    int f, r;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      valid_d = ($urandom_range(0, 3) != 0);
      reg_write_d = ($urandom_range(0, 2) != 0);
      rs1_d = 3'($urandom_range(0, 7)); rs2_d = 3'($urandom_range(0, 7));
      rs_fpu_d = $urandom_range(0, 1); rd_d = 3'($urandom_range(0, 7));
      rd_fpu_d = $urandom_range(0, 1); lat_d = 4'($urandom_range(0, 5));
      flush_d = ($urandom_range(0, 9) == 0); kill_e = ($urandom_range(0, 7) == 0);
      global_stall = ($urandom_range(0, 6) == 0);
      done_valid = ($urandom_range(0, 2) == 0);
      f = 0; r = 0;
      for (int t = 0; t < 16; t++) begin
        f = $urandom_range(0, 1); r = $urandom_range(0, 7);
        if (m_busy[f][r] && m_var[f][r]) break;
      end
      done_fpu = f[0]; done_rd = 3'(r);
      #1; model_comb(); n_cmp++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random c%0d: got %h expected %h", i, obs, exp_v); end
      advance();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    rst = 1;
    set_idle();
    @(negedge clk);
    test_reset();
    test_fixed_latency();
    test_variable_latency();
    test_kill();
    test_global_stall();
    test_full_waw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
